// File: rtl/axi_pkg.sv
// Shared AXI4 types, widths and helpers for the burst master and its memory slave.
package axi_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned MEM_DEPTH  = 1024;

    typedef logic [AXI_ADDR_W-1:0] addr_t;
    typedef logic [AXI_DATA_W-1:0] data_t;
    typedef logic [AXI_STRB_W-1:0] strb_t;
    typedef logic [AXI_LEN_W-1:0]  len_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    // Worse of two responses; encoding order matches severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle between the burst master and axi_dpmem.
interface axi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic              AW_VALID;
    logic              AW_READY;
    logic [ADDR_W-1:0] AW_ADDR;
    logic [LEN_W-1:0]  AW_LEN;
    logic [2:0]        AW_SIZE;
    logic [1:0]        AW_BURST;

    logic                W_VALID;
    logic                W_READY;
    logic [DATA_W-1:0]   W_DATA;
    logic [DATA_W/8-1:0] W_STRB;
    logic                W_LAST;

    logic       B_VALID;
    logic       B_READY;
    logic [1:0] B_RESP;

    logic              AR_VALID;
    logic              AR_READY;
    logic [ADDR_W-1:0] AR_ADDR;
    logic [LEN_W-1:0]  AR_LEN;
    logic [2:0]        AR_SIZE;
    logic [1:0]        AR_BURST;

    logic              R_VALID;
    logic              R_READY;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_LAST;

    modport mst_mp (
        output AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST,
        input  AW_READY,
        output W_VALID, W_DATA, W_STRB, W_LAST,
        input  W_READY,
        input  B_VALID, B_RESP,
        output B_READY,
        output AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST,
        input  AR_READY,
        input  R_VALID, R_DATA, R_RESP, R_LAST,
        output R_READY
    );

    modport slv_mp (
        input  AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST,
        output AW_READY,
        input  W_VALID, W_DATA, W_STRB, W_LAST,
        output W_READY,
        output B_VALID, B_RESP,
        input  B_READY,
        input  AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST,
        output AR_READY,
        output R_VALID, R_DATA, R_RESP, R_LAST,
        input  R_READY
    );
endinterface

// File: rtl/axi_4k_check.sv
// Flags an INCR burst whose byte span runs past the end of its 4 KB page.
module axi_4k_check
    import axi_pkg::*;
#(
    parameter int unsigned LEN_W  = AXI_LEN_W,
    parameter int unsigned DATA_W = AXI_DATA_W
) (
    input  logic [11:0]      addr_lo,
    input  logic [LEN_W-1:0] len,
    output logic             crosses_c
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SUM_W = LEN_W + 16;

    logic [SUM_W-1:0] span_end;

    always_comb begin
        span_end  = SUM_W'(addr_lo) + (SUM_W'(len) + SUM_W'(1)) * SUM_W'(BYTES);
        crosses_c = span_end > SUM_W'(4096);
    end
endmodule

// File: rtl/axi_burst_master.sv
// Command/stream to AXI4 INCR burst engine with independent write and read paths.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W,
    parameter int unsigned LEN_W  = AXI_LEN_W
) (
    input  logic                ACLK,
    input  logic                APRESETn,
    axi_if.mst_mp               axi_mst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                wr_done,
    output logic [1:0]          wr_resp,
    output logic                rd_done,
    output logic [1:0]          rd_resp
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [2:0]  AXSIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_ERR} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ERR} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic              up_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [LEN_W-1:0]  wr_len_q, rd_len_q, wr_cnt_q, rd_cnt_q;
    logic [1:0]        rd_acc_q;
    logic              rd_mis_q;

    logic [ADDR_W-1:0] cmd_addr_al_c;
    logic              crosses_c;
    logic              wr_cmd_c, rd_cmd_c;
    logic              aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic [1:0]        rd_worst_c;
    logic              rd_mis_c;

    assign cmd_addr_al_c = cmd_addr & ~ADDR_W'(STRB_W - 1);

    axi_4k_check #(.LEN_W(LEN_W), .DATA_W(DATA_W)) u_4k_check (
        .addr_lo   (cmd_addr_al_c[11:0]),
        .len       (cmd_len),
        .crosses_c (crosses_c)
    );

    // up_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = up_q && (cmd_write ? (wr_state_q == WR_IDLE) : (rd_state_q == RD_IDLE));
    assign wr_cmd_c  = cmd_valid && cmd_ready && cmd_write;
    assign rd_cmd_c  = cmd_valid && cmd_ready && !cmd_write;

    assign axi_mst.AW_VALID = (wr_state_q == WR_ADDR);
    assign axi_mst.AW_ADDR  = wr_addr_q;
    assign axi_mst.AW_LEN   = wr_len_q;
    assign axi_mst.AW_SIZE  = AXSIZE;
    assign axi_mst.AW_BURST = BURST_INCR;
    assign axi_mst.W_VALID  = (wr_state_q == WR_DATA) && wr_valid;
    assign axi_mst.W_DATA   = wr_data;
    assign axi_mst.W_STRB   = wr_strb;
    assign axi_mst.W_LAST   = (wr_cnt_q == wr_len_q);
    assign axi_mst.B_READY  = (wr_state_q == WR_RESP);
    assign wr_ready         = (wr_state_q == WR_DATA) && axi_mst.W_READY;

    assign axi_mst.AR_VALID = (rd_state_q == RD_ADDR);
    assign axi_mst.AR_ADDR  = rd_addr_q;
    assign axi_mst.AR_LEN   = rd_len_q;
    assign axi_mst.AR_SIZE  = AXSIZE;
    assign axi_mst.AR_BURST = BURST_INCR;
    assign axi_mst.R_READY  = (rd_state_q == RD_DATA) && rd_ready;
    assign rd_valid         = (rd_state_q == RD_DATA) && axi_mst.R_VALID;
    assign rd_data          = axi_mst.R_DATA;
    assign rd_last          = axi_mst.R_LAST;

    assign aw_hs_c = axi_mst.AW_VALID && axi_mst.AW_READY;
    assign w_hs_c  = axi_mst.W_VALID  && axi_mst.W_READY;
    assign b_hs_c  = axi_mst.B_VALID  && axi_mst.B_READY;
    assign ar_hs_c = axi_mst.AR_VALID && axi_mst.AR_READY;
    assign r_hs_c  = axi_mst.R_VALID  && axi_mst.R_READY;

    // A beat mismatches when R_LAST and the beat count disagree about the end.
    assign rd_worst_c = resp_max(rd_acc_q, axi_mst.R_RESP);
    assign rd_mis_c   = axi_mst.R_LAST != (rd_cnt_q == rd_len_q);

    always_ff @(posedge ACLK or negedge APRESETn) begin
        if (!APRESETn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (wr_cmd_c) wr_state_d = crosses_c ? WR_ERR : WR_ADDR;
            WR_ADDR: if (aw_hs_c) wr_state_d = WR_DATA;
            WR_DATA: if (w_hs_c && axi_mst.W_LAST) wr_state_d = WR_RESP;
            WR_RESP: if (b_hs_c) wr_state_d = WR_IDLE;
            WR_ERR:  wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (rd_cmd_c) rd_state_d = crosses_c ? RD_ERR : RD_ADDR;
            RD_ADDR: if (ar_hs_c) rd_state_d = RD_DATA;
            RD_DATA: if (r_hs_c && axi_mst.R_LAST) rd_state_d = RD_IDLE;
            RD_ERR:  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Burst context, beat counters and registered completion reporting.
    always_ff @(posedge ACLK or negedge APRESETn) begin
        if (!APRESETn) begin
            up_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            wr_cnt_q  <= '0;
            wr_done   <= 1'b0;
            wr_resp   <= RESP_OKAY;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            rd_cnt_q  <= '0;
            rd_acc_q  <= RESP_OKAY;
            rd_mis_q  <= 1'b0;
            rd_done   <= 1'b0;
            rd_resp   <= RESP_OKAY;
        end else begin
            up_q    <= 1'b1;
            wr_done <= 1'b0;
            rd_done <= 1'b0;

            if (wr_cmd_c) begin
                wr_addr_q <= cmd_addr_al_c;
                wr_len_q  <= cmd_len;
                wr_cnt_q  <= '0;
                if (crosses_c) begin
                    wr_done <= 1'b1;
                    wr_resp <= RESP_SLVERR;
                end
            end
            if (w_hs_c) wr_cnt_q <= wr_cnt_q + LEN_W'(1);
            if (b_hs_c) begin
                wr_done <= 1'b1;
                wr_resp <= axi_mst.B_RESP;
            end

            if (rd_cmd_c) begin
                rd_addr_q <= cmd_addr_al_c;
                rd_len_q  <= cmd_len;
                rd_cnt_q  <= '0;
                rd_acc_q  <= RESP_OKAY;
                rd_mis_q  <= 1'b0;
                if (crosses_c) begin
                    rd_done <= 1'b1;
                    rd_resp <= RESP_SLVERR;
                end
            end
            if (r_hs_c) begin
                rd_cnt_q <= rd_cnt_q + LEN_W'(1);
                rd_acc_q <= rd_worst_c;
                if (rd_mis_c) rd_mis_q <= 1'b1;
                if (axi_mst.R_LAST) begin
                    rd_done <= 1'b1;
                    rd_resp <= (rd_mis_q || rd_mis_c) ? RESP_SLVERR : rd_worst_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed scoreboard bench for axi_burst_master against a behavioural AXI memory slave.
module tb_axi_burst_master;
    import axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        APRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        wr_done, rd_done;
    logic [1:0]  wr_resp, rd_resp;

    always #5 ACLK = ~ACLK;

    axi_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) axi ();

    axi_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .ACLK(ACLK), .APRESETn(APRESETn), .axi_mst(axi),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_done(wr_done), .wr_resp(wr_resp), .rd_done(rd_done), .rd_resp(rd_resp)
    );

    // Behavioural slave: word memory, optional AW stall, one burst per direction.
    logic [31:0] mem [0:MEM_DEPTH-1];
    logic        w_act, b_pend, r_act;
    logic [9:0]  w_idx, r_idx;
    logic [7:0]  r_len, r_cnt;
    int unsigned aw_wait;
    int unsigned aw_stall_cfg = 0;

    assign axi.AW_READY = !w_act && !b_pend && (aw_wait >= aw_stall_cfg);
    assign axi.W_READY  = w_act;
    assign axi.B_VALID  = b_pend;
    assign axi.B_RESP   = 2'b00;
    assign axi.AR_READY = !r_act;
    assign axi.R_VALID  = r_act;
    assign axi.R_DATA   = mem[r_idx];
    assign axi.R_LAST   = (r_cnt == r_len);
    assign axi.R_RESP   = 2'b00;

    always @(posedge ACLK or negedge APRESETn) begin
        if (!APRESETn) begin
            w_act <= 1'b0; b_pend <= 1'b0; r_act <= 1'b0; aw_wait <= 0;
            w_idx <= '0; r_idx <= '0; r_len <= '0; r_cnt <= '0;
        end else begin
            if (axi.AW_VALID && axi.AW_READY) begin
                w_act   <= 1'b1;
                w_idx   <= axi.AW_ADDR[11:2];
                aw_wait <= 0;
            end else if (axi.AW_VALID) begin
                aw_wait <= aw_wait + 1;
            end
            if (axi.W_VALID && axi.W_READY) begin
                for (int b = 0; b < 4; b++)
                    if (axi.W_STRB[b]) mem[w_idx][b*8 +: 8] <= axi.W_DATA[b*8 +: 8];
                w_idx <= w_idx + 10'd1;
                if (axi.W_LAST) begin
                    w_act  <= 1'b0;
                    b_pend <= 1'b1;
                end
            end
            if (axi.B_VALID && axi.B_READY) b_pend <= 1'b0;
            if (axi.AR_VALID && axi.AR_READY) begin
                r_act <= 1'b1;
                r_idx <= axi.AR_ADDR[11:2];
                r_len <= axi.AR_LEN;
                r_cnt <= '0;
            end
            if (axi.R_VALID && axi.R_READY) begin
                r_idx <= r_idx + 10'd1;
                r_cnt <= r_cnt + 8'd1;
                if (axi.R_LAST) r_act <= 1'b0;
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] shadow [0:MEM_DEPTH-1];
    logic        exp_wlast [$];
    logic [32:0] exp_rd [$];
    logic [1:0]  exp_wresp [$];
    logic [1:0]  exp_rresp [$];
    int          wr_done_cnt = 0;
    int          rd_done_cnt = 0;
    logic        hs_cmd = 1'b0;
    logic        hs_wr = 1'b0;
    logic        rd_toggle = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic miss(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=none expected=event", tag);
    endtask

    // One clock: sample outputs mid-cycle, score them, then step past the next edge.
    task automatic tick();
        logic [32:0] e;
        @(negedge ACLK);
        hs_cmd = cmd_valid && cmd_ready;
        hs_wr  = wr_valid && wr_ready;
        if (axi.W_VALID && axi.W_READY) begin
            if (exp_wlast.size() == 0) miss("w_beat_expected");
            else chk("w_last", axi.W_LAST, exp_wlast.pop_front());
        end
        if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) miss("rd_beat_expected");
            else begin
                e = exp_rd.pop_front();
                chk("rd_data", rd_data, e[31:0]);
                chk("rd_last", rd_last, e[32]);
            end
        end
        if (rd_toggle && axi.R_VALID) chk("r_ready_mirror", axi.R_READY, rd_ready);
        if (wr_done) begin
            wr_done_cnt++;
            if (exp_wresp.size() == 0) miss("wr_done_expected");
            else chk("wr_resp", wr_resp, exp_wresp.pop_front());
        end
        if (rd_done) begin
            rd_done_cnt++;
            if (exp_rresp.size() == 0) miss("rd_done_expected");
            else chk("rd_resp", rd_resp, exp_rresp.pop_front());
        end
        @(posedge ACLK);
        #1;
        if (rd_toggle) rd_ready = ~rd_ready;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        do begin tick(); n++; end while (!hs_cmd && n < 50);
        if (!hs_cmd) miss("cmd_handshake");
        cmd_valid = 1'b0;
    endtask

    task automatic feed_beats(input logic [31:0] base, input int len, input logic [31:0] a, input int nbeats);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            shadow[((a & 32'hFFF) >> 2) + i] = base + i;
            exp_wlast.push_back(i == len);
            wr_valid = 1'b1; wr_data = base + i; wr_strb = 4'hF;
            n = 0;
            do begin tick(); n++; end while (!hs_wr && n < 50);
            if (!hs_wr) miss("w_beat_handshake");
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_dones(input int wt, input int rt);
        int n = 0;
        while ((wr_done_cnt < wt || rd_done_cnt < rt) && n < 200) begin tick(); n++; end
        if (wr_done_cnt < wt) miss("wr_done_timeout");
        if (rd_done_cnt < rt) miss("rd_done_timeout");
    endtask

    task automatic push_read(input logic [31:0] a, input int len);
        for (int i = 0; i <= len; i++)
            exp_rd.push_back({(i == len), shadow[((a & 32'hFFF) >> 2) + i]});
        exp_rresp.push_back(2'b00);
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input logic [31:0] base);
        int wt = wr_done_cnt + 1;
        exp_wresp.push_back(2'b00);
        send_cmd(1'b1, a, 8'(len));
        feed_beats(base, len, a, len + 1);
        wait_dones(wt, rd_done_cnt);
    endtask

    task automatic do_read(input logic [31:0] a, input int len);
        int rt = rd_done_cnt + 1;
        push_read(a, len);
        send_cmd(1'b0, a, 8'(len));
        wait_dones(wr_done_cnt, rt);
    endtask

    initial begin
        int wt, rt;
        APRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_aw_valid", axi.AW_VALID, 1'b0);
        chk("rst_ar_valid", axi.AR_VALID, 1'b0);
        chk("rst_b_ready", axi.B_READY, 1'b0);
        chk("rst_r_ready", axi.R_READY, 1'b0);
        chk("rst_wr_done", wr_done, 1'b0);
        chk("rst_rd_done", rd_done, 1'b0);
        chk("rst_wr_resp", wr_resp, 2'b00);
        chk("rst_rd_resp", rd_resp, 2'b00);
        APRESETn = 1'b1;
        #1 chk("release_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        chk("release_cmd_ready_high", cmd_ready, 1'b1);

        // Basic 4-beat write then read-back.
        do_write(32'h10, 3, 32'hA0);
        do_read(32'h10, 3);

        // AW stalled for 5 cycles with write data already offered.
        aw_stall_cfg = 5;
        wt = wr_done_cnt + 1;
        exp_wresp.push_back(2'b00);
        wr_valid = 1'b1; wr_data = 32'hB0; wr_strb = 4'hF;
        send_cmd(1'b1, 32'h40, 8'd1);
        chk("aw_len", axi.AW_LEN, 8'd1);
        chk("aw_size", axi.AW_SIZE, 3'd2);
        chk("aw_burst", axi.AW_BURST, 2'b01);
        for (int c = 0; c < 6; c++) begin
            chk("aw_valid_hold", axi.AW_VALID, 1'b1);
            chk("aw_addr_hold", axi.AW_ADDR, 32'h40);
            chk("w_valid_before_aw", axi.W_VALID, 1'b0);
            tick();
        end
        chk("aw_valid_dropped", axi.AW_VALID, 1'b0);
        chk("w_valid_after_aw", axi.W_VALID, 1'b1);
        aw_stall_cfg = 0;
        feed_beats(32'hB0, 1, 32'h40, 2);
        wait_dones(wt, rd_done_cnt);

        // Burst crossing the 4 KB page is refused without AXI traffic.
        exp_wresp.push_back(2'b10);
        wr_valid = 1'b1; wr_data = 32'hDEAD; wr_strb = 4'hF;
        send_cmd(1'b1, 32'hFF8, 8'd3);
        chk("err_wr_done", wr_done, 1'b1);
        chk("err_wr_resp", wr_resp, 2'b10);
        chk("err_no_aw", axi.AW_VALID, 1'b0);
        chk("err_wr_ready", wr_ready, 1'b0);
        chk("err_cmd_busy", cmd_ready, 1'b0);
        tick();
        chk("err_idle", cmd_ready, 1'b1);
        chk("err_pulse_end", wr_done, 1'b0);
        chk("err_no_aw_after", axi.AW_VALID, 1'b0);
        chk("err_wr_ready_after", wr_ready, 1'b0);
        wr_valid = 1'b0;

        // Burst ending exactly at the page boundary is legal.
        do_write(32'hFF0, 3, 32'hC0);
        do_read(32'hFF0, 3);

        // Write and read in flight together.
        wt = wr_done_cnt + 1;
        rt = rd_done_cnt + 1;
        exp_wresp.push_back(2'b00);
        push_read(32'h40, 1);
        send_cmd(1'b1, 32'h100, 8'd0);
        send_cmd(1'b0, 32'h40, 8'd1);
        chk("ar_valid", axi.AR_VALID, 1'b1);
        chk("ar_addr", axi.AR_ADDR, 32'h40);
        chk("ar_len", axi.AR_LEN, 8'd1);
        chk("ar_size", axi.AR_SIZE, 3'd2);
        chk("ar_burst", axi.AR_BURST, 2'b01);
        feed_beats(32'hD0, 0, 32'h100, 1);
        wait_dones(wt, rt);
        chk("conc_wr_done_cnt", wr_done_cnt, wt);
        chk("conc_rd_done_cnt", rd_done_cnt, rt);
        do_read(32'h100, 0);

        // Read stream with a toggling consumer.
        rt = rd_done_cnt + 1;
        push_read(32'h10, 3);
        rd_toggle = 1'b1;
        send_cmd(1'b0, 32'h10, 8'd3);
        wait_dones(wr_done_cnt, rt);
        rd_toggle = 1'b0;
        rd_ready = 1'b1;
        chk("toggle_all_beats", exp_rd.size(), 0);

        // Reset in the middle of a write burst.
        wt = wr_done_cnt;
        send_cmd(1'b1, 32'h200, 8'd3);
        feed_beats(32'hE0, 3, 32'h200, 2);
        wr_valid = 1'b1; wr_data = 32'hE2; wr_strb = 4'hF;
        #1 chk("pre_rst_w_valid", axi.W_VALID, 1'b1);
        APRESETn = 1'b0;
        #1;
        chk("mid_rst_w_valid", axi.W_VALID, 1'b0);
        chk("mid_rst_wr_ready", wr_ready, 1'b0);
        chk("mid_rst_aw_valid", axi.AW_VALID, 1'b0);
        chk("mid_rst_b_ready", axi.B_READY, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        wr_valid = 1'b0;
        exp_wlast.delete();
        repeat (2) tick();
        chk("mid_rst_no_done", wr_done_cnt, wt);
        APRESETn = 1'b1;
        repeat (2) tick();
        do_write(32'h200, 3, 32'hF0);
        do_read(32'h200, 3);
        repeat (3) tick();
        chk("final_w_queue_empty", exp_wlast.size(), 0);
        chk("final_rd_queue_empty", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

AXI4 master-side burst engine that drives the dual-port AXI memory slave (axi_dpmem) from a simple command/stream front end. It accepts one write or read command per handshake, issues the matching AW or AR address phase as an INCR burst, moves write beats from an input stream or read beats to an output stream, and reports completion with the AXI response. Write and read paths are independent FSMs and may be active at the same time; each path has one outstanding burst.

## Interface
Parameters:
- ADDR_W, 32, address width; matches addr_t.
- DATA_W, 32, data width; matches data_t; STRB width is DATA_W/8.
- LEN_W, 8, burst length field width (beats = len+1).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- APRESETn  in  1  asynchronous active-low reset.
- axi_mst  modport  axi_if.mst_mp  AW_*, W_*, B_*, AR_*, R_* channels toward axi_dpmem.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  byte start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_data / wr_strb  in  DATA_W / DATA_W/8  write beat payload.
- wr_valid  in  1 / wr_ready  out  1  write stream handshake.
- rd_data  out  DATA_W; rd_last  out  1; rd_valid  out  1 / rd_ready  in  1  read stream.
- wr_done  out  1  one-cycle pulse, write burst finished; wr_resp  out  2.
- rd_done  out  1  one-cycle pulse, read burst finished; rd_resp  out  2.

## Operation
- cmd_ready = cmd_write ? (wr_state==WR_IDLE) : (rd_state==RD_IDLE).
- AW_BURST/AR_BURST fixed INCR (2'b01); AW_SIZE/AR_SIZE fixed log2(DATA_W/8); address low log2(DATA_W/8) bits forced to 0.
- 4 KB rule: if (addr[11:0] + (len+1)*DATA_W/8) > 4096, burst is not issued; path goes straight to done with resp SLVERR (2'b10), no AXI traffic, no write beats consumed.
- Write FSM: WR_IDLE -> WR_ADDR (AW_VALID=1, held with stable AW_* until AW_READY) -> WR_DATA -> WR_RESP (B_READY=1) -> WR_IDLE.
- WR_DATA: W_VALID=wr_valid, wr_ready=W_READY, W_DATA/W_STRB pass through; beat counter increments on W handshake; W_LAST=(cnt==len). Last handshake -> WR_RESP.
- B handshake: wr_resp<=B_RESP, wr_done pulses.
- Read FSM: RD_IDLE -> RD_ADDR (AR_VALID until AR_READY) -> RD_DATA -> RD_IDLE.
- RD_DATA: rd_valid=R_VALID, R_READY=rd_ready, rd_data/rd_last pass through. rd_resp accumulates worst (max) R_RESP across beats; on R_LAST handshake rd_done pulses.
- R_LAST arriving before counter reaches len, or counter reaching len without R_LAST: burst ends on R_LAST; rd_resp forced SLVERR on mismatch.

## Timing
- Reset: all *_VALID, B_READY, R_READY, wr_ready, rd_valid, cmd_ready, wr_done, rd_done = 0; wr_resp, rd_resp = 0; FSMs to IDLE, counters 0. First cmd_ready one cycle after reset release.
- Cmd accepted cycle N -> AW_VALID/AR_VALID high at N+1.
- AW handshake cycle M -> W_VALID may rise at M+1 (no W before AW).
- Last W handshake cycle K -> B_READY at K+1; B handshake cycle J -> wr_done at J+1, cmd_ready (write) at J+1.
- R_LAST handshake cycle J -> rd_done at J+1, read cmd_ready at J+1.
- 4 KB error: done pulse at N+1, idle at N+2.
- len=0: single beat, W_LAST on first beat.
- Concurrent write and read commands serviced independently; no cross-path stalls.
- Reset mid-burst: immediate abandon, outputs to reset values; no done pulse.

## Structure
- Shared package axi_pkg: addr_t, data_t, strb_t, len_t, burst_t enum (FIXED/INCR/WRAP), resp_t enum (OKAY/EXOKAY/SLVERR/DECERR), `MEM_DEPTH.
- FSM state enums local to module.
- One sub-module natural: axi_4k_check (combinational addr/len/size -> crosses flag), shared by both paths.

## Test plan
- Write addr 0x10, len 3, data 0xA0..0xA3, strb 0xF -> 4 W beats, W_LAST on 4th only, wr_done with wr_resp=0; read back len 3 -> rd_data 0xA0..0xA3, rd_last on 4th, rd_resp=0.
- AW_READY held low 5 cycles -> AW_VALID and AW_ADDR stable throughout, no W_VALID until cycle after handshake.
- Write addr 0xFF8, len 3 (crosses 4 KB) -> no AW_VALID, wr_done next cycle, wr_resp=2'b10, wr_ready stays 0.
- Simultaneous write (addr 0x100, len 0) and read (addr 0x40, len 1) -> both complete, independent done pulses.
- rd_ready toggling 1/0 each cycle -> R_READY mirrors it, no beat lost or duplicated.
- APRESETn asserted during WR_DATA beat 2 -> all VALIDs 0 asynchronously, no wr_done; new write after release completes normally.
